msg_parser: RTL and testbench

Upstream stage of the message datapath. Accepts a packetised AXI4-Stream byte stream (8-byte beats, `tkeep` qualified), decodes the packet header and the per-message length fields, and reassembles each message payload into one wide word. Completed messages are emitted as single-cycle `msg_valid` pulses with a byte count. Malformed, truncated or user-flagged packets are reported on `msg_error` and discarded.

---
 rtl/msg_parser_if.sv | 23 ++
 rtl/msg_parser.sv | 172 +++++++++++++++++
 tb/tb_msg_parser.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/msg_parser_if.sv
// AXI4-Stream byte-stream port into the message parser.
// master drives beats, slave returns s_tready.
interface msg_parser_if #(
  parameter int DATA_BYTES  = 8,
  parameter int TKEEP_WIDTH = 8
);
  logic                    s_tvalid;
  logic                    s_tready;
  logic                    s_tlast;
  logic                    s_tuser;
  logic [TKEEP_WIDTH-1:0]  s_tkeep;
  logic [8*DATA_BYTES-1:0] s_tdata;

  modport master (
    output s_tvalid, s_tlast, s_tuser, s_tkeep, s_tdata,
    input  s_tready
  );

  modport slave (
    input  s_tvalid, s_tlast, s_tuser, s_tkeep, s_tdata,
    output s_tready
  );
endinterface

// File: rtl/msg_parser.sv
// Packet header / length decoder that reassembles each message payload into one wide word.
// Every kept byte of a beat is walked through the per-byte FSM in a single cycle.
//
// state   | meaning
// CNT_LO  | expecting message count, low byte
// CNT_HI  | expecting message count, high byte
// LEN_LO  | expecting message length, low byte
// LEN_HI  | expecting message length, high byte (range checked here)
// PAYLOAD | collecting payload bytes into the assembly buffer
// DRAIN   | discarding bytes until tlast
module msg_parser #(
  parameter int DATA_BYTES    = 8,
  parameter int TKEEP_WIDTH   = 8,
  parameter int MAX_MSG_BYTES = 32,
  parameter int MIN_MSG_BYTES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  msg_parser_if.slave                s_axis,
  output logic [8*MAX_MSG_BYTES-1:0] msg_data,
  output logic [5:0]                 msg_len,
  output logic                       msg_valid,
  output logic                       msg_error
);

  localparam int BUF_W = 8*MAX_MSG_BYTES;
  localparam int IDX_W = $clog2(BUF_W);
  localparam logic [15:0] MIN_LEN = 16'(MIN_MSG_BYTES);
  localparam logic [15:0] MAX_LEN = 16'(MAX_MSG_BYTES);

  typedef enum logic [2:0] {CNT_LO, CNT_HI, LEN_LO, LEN_HI, PAYLOAD, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [5:0]         len_q, len_d;
  logic [5:0]         wr_idx_q, wr_idx_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic               err_seen_q, err_seen_d;
  logic [BUF_W-1:0]   msg_data_q, msg_data_d;
  logic [5:0]         msg_len_q, msg_len_d;
  logic               msg_valid_q, msg_valid_d;
  logic               msg_error_q, msg_error_d;

  logic               accept;
  logic               done_ev, err_ev;
  logic [BUF_W-1:0]   done_buf;
  logic [5:0]         done_len;
  logic [7:0]         byte_v;
  logic [15:0]        len_full;

  assign s_axis.s_tready = rst;
  assign accept          = s_axis.s_tvalid && s_axis.s_tready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CNT_LO;
      cnt_q       <= '0;
      len_lo_q    <= '0;
      len_q       <= '0;
      wr_idx_q    <= '0;
      buf_q       <= '0;
      err_seen_q  <= 1'b0;
      msg_data_q  <= '0;
      msg_len_q   <= '0;
      msg_valid_q <= 1'b0;
      msg_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      wr_idx_q    <= wr_idx_d;
      buf_q       <= buf_d;
      err_seen_q  <= err_seen_d;
      msg_data_q  <= msg_data_d;
      msg_len_q   <= msg_len_d;
      msg_valid_q <= msg_valid_d;
      msg_error_q <= msg_error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    wr_idx_d   = wr_idx_q;
    buf_d      = buf_q;
    err_seen_d = err_seen_q;
    done_ev    = 1'b0;
    err_ev     = 1'b0;
    done_buf   = '0;
    done_len   = '0;
    byte_v     = '0;
    len_full   = '0;
    if (accept) begin
      for (int i = 0; i < TKEEP_WIDTH; i++) begin
        if (s_axis.s_tkeep[i]) begin
          byte_v = s_axis.s_tdata[8*i +: 8];
          case (state_d)
            CNT_LO: begin
              cnt_d   = {8'h00, byte_v};
              state_d = CNT_HI;
            end
            CNT_HI: begin
              cnt_d   = {byte_v, cnt_d[7:0]};
              state_d = (cnt_d == 16'd0) ? DRAIN : LEN_LO;
            end
            LEN_LO: begin
              len_lo_d = byte_v;
              state_d  = LEN_HI;
            end
            LEN_HI: begin
              // Full 16-bit compare so that e.g. 0x0108 cannot alias to a legal length.
              len_full = {byte_v, len_lo_d};
              if (len_full < MIN_LEN || len_full > MAX_LEN) begin
                if (!err_seen_d) err_ev = 1'b1;
                err_seen_d = 1'b1;
                state_d    = DRAIN;
              end else begin
                len_d    = len_full[5:0];
                wr_idx_d = '0;
                state_d  = PAYLOAD;
              end
            end
            PAYLOAD: begin
              buf_d[IDX_W'({wr_idx_d, 3'b000}) +: 8] = byte_v;
              wr_idx_d = wr_idx_d + 6'd1;
              if (wr_idx_d == len_d) begin
                done_ev  = 1'b1;
                done_buf = buf_d;
                done_len = len_d;
                buf_d    = '0;
                cnt_d    = cnt_d - 16'd1;
                state_d  = (cnt_d != 16'd0) ? LEN_LO : DRAIN;
              end
            end
            DRAIN: begin
              if (!err_seen_d) err_ev = 1'b1;
              err_seen_d = 1'b1;
            end
            default: state_d = CNT_LO;
          endcase
        end
      end
      if (s_axis.s_tlast) begin
        if ((state_d != DRAIN || s_axis.s_tuser) && !err_seen_d) err_ev = 1'b1;
        state_d    = CNT_LO;
        cnt_d      = '0;
        len_lo_d   = '0;
        len_d      = '0;
        wr_idx_d   = '0;
        buf_d      = '0;
        err_seen_d = 1'b0;
      end
    end
  end

  always_comb begin
    msg_valid_d = done_ev && !(s_axis.s_tlast && s_axis.s_tuser);
    msg_error_d = err_ev;
    msg_data_d  = msg_valid_d ? done_buf : msg_data_q;
    msg_len_d   = msg_valid_d ? done_len : msg_len_q;
  end

  assign msg_data  = msg_data_q;
  assign msg_len   = msg_len_q;
  assign msg_valid = msg_valid_q;
  assign msg_error = msg_error_q;

endmodule

// File: tb/tb_msg_parser.sv
// Scoreboard bench for msg_parser: packets are built byte by byte, expected
// pulses are queued as each packet is built and popped when the DUT pulses.
module tb_msg_parser;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] msg_data;
  logic [5:0]   msg_len;
  logic         msg_valid;
  logic         msg_error;

  msg_parser_if #(.DATA_BYTES(8), .TKEEP_WIDTH(8)) bus ();

  msg_parser dut (
    .clk       (clk),
    .rst       (rst),
    .s_axis    (bus),
    .msg_data  (msg_data),
    .msg_len   (msg_len),
    .msg_valid (msg_valid),
    .msg_error (msg_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           v;
    bit           e;
    logic [5:0]   len;
    logic [255:0] data;
  } exp_t;

  exp_t         sb[$];
  logic [7:0]   pkt[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [5:0]   last_len;
  logic [255:0] last_data;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void add_hdr(input logic [15:0] cnt);
    pkt.push_back(cnt[7:0]);
    pkt.push_back(cnt[15:8]);
  endfunction

  function automatic logic [255:0] add_msg(input logic [15:0] len, input int n, input bit seq);
    logic [255:0] d;
    logic [7:0]   b;
    d = '0;
    pkt.push_back(len[7:0]);
    pkt.push_back(len[15:8]);
    for (int i = 0; i < n; i++) begin
      b = seq ? 8'(i + 1) : 8'($urandom_range(0, 255));
      pkt.push_back(b);
      if (i < 32) d[8*i +: 8] = b;
    end
    return d;
  endfunction

  task automatic push_exp(input bit v, input bit e, input logic [5:0] len, input logic [255:0] data);
    exp_t x;
    x.v = v; x.e = e; x.len = len; x.data = data;
    sb.push_back(x);
    if (v) begin
      last_len  = len;
      last_data = data;
    end
  endtask

  task automatic send_pkt(input bit tuser, input int max_beats, input int gap);
    int nb;
    nb = (pkt.size() + 7) / 8;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      logic [63:0] d;
      logic [7:0]  k;
      d = '0;
      k = '0;
      for (int j = 0; j < 8; j++) begin
        if (b*8 + j < pkt.size()) begin
          d[8*j +: 8] = pkt[b*8 + j];
          k[j] = 1'b1;
        end
      end
      bus.s_tdata  = d;
      bus.s_tkeep  = k;
      bus.s_tlast  = (b == nb - 1);
      bus.s_tuser  = (b == nb - 1) && tuser;
      bus.s_tvalid = 1'b1;
      @(posedge clk); #1;
      if (gap > 0) begin
        bus.s_tvalid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.s_tuser  = 1'b0;
    pkt.delete();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 256'(sb.size()), 256'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && (msg_valid || msg_error)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {254'd0, msg_valid, msg_error}, 256'd0);
      end else begin
        e = sb.pop_front();
        chk("valid", 256'(msg_valid), 256'(e.v));
        chk("error", 256'(msg_error), 256'(e.e));
        if (e.v) begin
          chk("len", 256'(msg_len), 256'(e.len));
          chk("data", msg_data, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] d;
    rst          = 1'b0;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.s_tuser  = 1'b0;
    bus.s_tkeep  = '0;
    bus.s_tdata  = '0;

    repeat (2) @(negedge clk);
    chk("rst_tready", 256'(bus.s_tready), 256'd0);
    chk("rst_valid",  256'(msg_valid), 256'd0);
    chk("rst_error",  256'(msg_error), 256'd0);
    chk("rst_len",    256'(msg_len), 256'd0);
    chk("rst_data",   msg_data, 256'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("tready_up", 256'(bus.s_tready), 256'd1);
    @(posedge clk); #1;

    // single 8-byte message, sequential payload
    add_hdr(16'd1);
    d = add_msg(16'd8, 8, 1'b1);
    push_exp(1'b1, 1'b0, 6'd8, d);
    send_pkt(1'b0, 99, 0);
    wait_idle();
    chk("t1_data_fixed", msg_data, 256'h0807060504030201);

    // count=2 (32 and 9 bytes) then a back-to-back packet with idle gaps
    add_hdr(16'd2);
    d = add_msg(16'd32, 32, 1'b0);
    push_exp(1'b1, 1'b0, 6'd32, d);
    d = add_msg(16'd9, 9, 1'b0);
    push_exp(1'b1, 1'b0, 6'd9, d);
    send_pkt(1'b0, 99, 0);
    add_hdr(16'd1);
    d = add_msg(16'd10, 10, 1'b0);
    push_exp(1'b1, 1'b0, 6'd10, d);
    send_pkt(1'b0, 99, 2);
    wait_idle();

    // illegal lengths: below min, above max, high byte set
    add_hdr(16'd1);
    d = add_msg(16'h0007, 7, 1'b0);
    push_exp(1'b0, 1'b1, 6'd0, 256'd0);
    send_pkt(1'b0, 99, 0);
    add_hdr(16'd1);
    d = add_msg(16'h0021, 33, 1'b0);
    push_exp(1'b0, 1'b1, 6'd0, 256'd0);
    send_pkt(1'b0, 99, 0);
    add_hdr(16'd1);
    d = add_msg(16'h0108, 8, 1'b0);
    push_exp(1'b0, 1'b1, 6'd0, 256'd0);
    send_pkt(1'b0, 99, 0);
    add_hdr(16'd1);
    d = add_msg(16'd8, 8, 1'b0);
    push_exp(1'b1, 1'b0, 6'd8, d);
    send_pkt(1'b0, 99, 0);
    wait_idle();

    // truncation after message 1 plus one length byte: valid and error together
    add_hdr(16'd2);
    d = add_msg(16'd8, 8, 1'b0);
    pkt.push_back(8'h09);
    push_exp(1'b1, 1'b1, 6'd8, d);
    send_pkt(1'b0, 99, 0);
    wait_idle();

    // count=0 exactly: silent; count=0 with a stray byte: error
    add_hdr(16'd0);
    send_pkt(1'b0, 99, 0);
    add_hdr(16'd0);
    pkt.push_back(8'h55);
    push_exp(1'b0, 1'b1, 6'd0, 256'd0);
    send_pkt(1'b0, 99, 0);
    // stray byte after the final message, same beat as completion
    add_hdr(16'd1);
    d = add_msg(16'd8, 8, 1'b0);
    pkt.push_back(8'hAA);
    push_exp(1'b1, 1'b1, 6'd8, d);
    send_pkt(1'b0, 99, 0);
    wait_idle();

    // tuser on last beat: error only, outputs hold
    add_hdr(16'd1);
    d = add_msg(16'd10, 10, 1'b0);
    push_exp(1'b0, 1'b1, 6'd0, 256'd0);
    send_pkt(1'b1, 99, 0);
    wait_idle();
    chk("tuser_len_hold", 256'(msg_len), 256'(last_len));
    chk("tuser_data_hold", msg_data, last_data);

    // bad length plus tuser: still a single error pulse
    add_hdr(16'd1);
    d = add_msg(16'h0007, 7, 1'b0);
    push_exp(1'b0, 1'b1, 6'd0, 256'd0);
    send_pkt(1'b1, 99, 0);
    wait_idle();

    // reset mid-payload, then a shorter fresh message
    add_hdr(16'd1);
    d = add_msg(16'd32, 32, 1'b0);
    send_pkt(1'b0, 2, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_tready", 256'(bus.s_tready), 256'd0);
    chk("mid_rst_len",    256'(msg_len), 256'd0);
    chk("mid_rst_data",   msg_data, 256'd0);
    chk("mid_rst_valid",  256'(msg_valid), 256'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    add_hdr(16'd1);
    d = add_msg(16'd9, 9, 1'b0);
    push_exp(1'b1, 1'b0, 6'd9, d);
    send_pkt(1'b0, 99, 0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
